// File: rtl/irq_arbiter.sv
// Multi-source interrupt arbiter feeding CP0's single external interrupt input.
// Per-source sync/pending slices feed a priority picker and a REQ/SERVICE handshake FSM.

module irq_arbiter_src #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic irq,
   input  logic edge_mode,
   input  logic edge_chg,
   input  logic clr,
   output logic pend
);
   logic [SYNC_STAGES-1:0] sync;
   logic                   s;
   logic                   s_d;

   assign s = sync[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         sync <= '0;
         s_d  <= 1'b0;
         pend <= 1'b0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], irq};
         s_d  <= s;
         // A fresh edge outranks a same-cycle clear so no interrupt is lost.
         if (edge_chg)
            pend <= 1'b0;
         else if (!edge_mode)
            pend <= s;
         else if (s && !s_d)
            pend <= 1'b1;
         else if (clr)
            pend <= 1'b0;
      end
   end
endmodule

module irq_arbiter #(
   parameter int N_SRC       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int ROUND_ROBIN = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_SRC-1:0] irq_src,
   input  logic             cfg_we,
   input  logic [1:0]       cfg_addr,
   input  logic [31:0]      cfg_wdata,
   output logic [31:0]      cfg_rdata,
   input  logic             eret,
   input  logic             ir_taken,
   output logic             ir_out,
   output logic [3:0]       active_id,
   output logic             busy
);
   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] REQ     = 2'd1;
   localparam logic [1:0] SERVICE = 2'd2;

   logic [1:0]         state;
   logic [N_SRC-1:0]   mask;
   logic [N_SRC-1:0]   edge_mode;
   logic [N_SRC-1:0]   edge_chg;
   logic [N_SRC-1:0]   pend;
   logic [N_SRC-1:0]   elig;
   logic [N_SRC-1:0]   w1c;
   logic [N_SRC-1:0]   take_clr;
   logic [N_SRC-1:0]   rot;
   logic [2*N_SRC-1:0] dbl;
   logic [3:0]         rr_ptr;
   logic [3:0]         base;
   logic [3:0]         win;
   logic [4:0]         kk;
   logic [4:0]         widx;
   logic               found;
   logic               taken;
   logic               unused_wdata;

   assign unused_wdata = ^cfg_wdata[31:N_SRC];
   assign taken        = (state == REQ) && ir_taken;
   assign elig         = pend & mask;
   assign edge_chg     = (cfg_we && cfg_addr == 2'd2) ? (cfg_wdata[N_SRC-1:0] ^ edge_mode) : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         mask      <= '0;
         edge_mode <= '0;
      end else if (cfg_we) begin
         if (cfg_addr == 2'd0) mask      <= cfg_wdata[N_SRC-1:0];
         if (cfg_addr == 2'd2) edge_mode <= cfg_wdata[N_SRC-1:0];
      end
   end

   for (genvar i = 0; i < N_SRC; i++) begin : g_src
      assign w1c[i]      = cfg_we && (cfg_addr == 2'd1) && cfg_wdata[i];
      assign take_clr[i] = taken && (active_id == 4'(i));
      irq_arbiter_src #(.SYNC_STAGES(SYNC_STAGES)) u_src (
         .clk       (clk),
         .rst       (rst),
         .irq       (irq_src[i]),
         .edge_mode (edge_mode[i]),
         .edge_chg  (edge_chg[i]),
         .clr       (w1c[i] || take_clr[i]),
         .pend      (pend[i])
      );
   end

   // Rotate eligibility so the search always starts at bit 0, then map back.
   always_comb begin
      base  = (ROUND_ROBIN != 0) ? rr_ptr : 4'd0;
      dbl   = {elig, elig} >> base;
      rot   = dbl[N_SRC-1:0];
      found = |elig;
      kk    = '0;
      for (int k = N_SRC - 1; k >= 0; k--)
         if (rot[k]) kk = 5'(k);
      widx = kk + {1'b0, base};
      if (widx >= 5'(N_SRC)) widx = widx - 5'(N_SRC);
      win = widx[3:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         active_id <= '0;
         rr_ptr    <= '0;
      end else begin
         case (state)
            IDLE: if (found) begin
               active_id <= win;
               state     <= REQ;
            end
            // Request is held regardless of source/mask changes until CP0 takes it.
            REQ: if (ir_taken) begin
               state  <= SERVICE;
               rr_ptr <= (active_id == 4'(N_SRC - 1)) ? 4'd0 : active_id + 4'd1;
            end
            SERVICE: if (eret) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign ir_out = (state == REQ);
   assign busy   = (state == REQ) || (state == SERVICE);

   always_comb begin
      cfg_rdata = '0;
      case (cfg_addr)
         2'd0: cfg_rdata[N_SRC-1:0] = mask;
         2'd1: cfg_rdata[N_SRC-1:0] = pend;
         2'd2: cfg_rdata[N_SRC-1:0] = edge_mode;
         default: cfg_rdata = {busy, 27'b0, active_id};
      endcase
   end
endmodule
